// File: rtl/ma_stage.sv
// Memory-access pipeline stage: issues data-memory loads/stores over a req/ack bus,
// stalls upstream while a transfer is outstanding, and owns the MA/WB register.
module ma_stage #(
  parameter int WIDTH     = 32,
  parameter int WB_WIDTH  = 2,
  parameter int RDS_WIDTH = 5,
  parameter int TIMEOUT   = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WB_WIDTH-1:0]  i_WB_Ctrl,
  input  logic [4:0]           i_MEM_Ctrl,
  input  logic [WIDTH-1:0]     i_ALU_rslt,
  input  logic [WIDTH-1:0]     i_Rs2_val,
  input  logic [RDS_WIDTH-1:0] i_Rs2_addr,
  input  logic [RDS_WIDTH-1:0] i_Rds_addr,
  input  logic [WIDTH-1:0]     i_PC,
  input  logic                 i_Fwrd_Store,
  input  logic [WIDTH-1:0]     i_Data_From_WB,
  input  logic                 i_MAWB_flush,
  input  logic                 i_MAWB_stall,
  output logic                 o_dmem_req,
  output logic                 o_dmem_we,
  output logic [WIDTH-1:0]     o_dmem_addr,
  output logic [WIDTH-1:0]     o_dmem_wdata,
  output logic [3:0]           o_dmem_be,
  input  logic                 i_dmem_ack,
  input  logic [WIDTH-1:0]     i_dmem_rdata,
  output logic                 o_MA_stall,
  output logic                 o_misaligned,
  output logic                 o_bus_err,
  output logic [WIDTH-1:0]     o_Data_To_Fwd,
  output logic [WB_WIDTH-1:0]  o_MAWB_WB,
  output logic [WIDTH-1:0]     o_MAWB_Data,
  output logic [RDS_WIDTH-1:0] o_MAWB_Rds_addr,
  output logic [WIDTH-1:0]     o_MAWB_PC
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t               state;
  logic [3:0]           tmo_cnt;
  logic [WIDTH-1:0]     addr_q, wdata_q, cap_q, pc_q;
  logic [3:0]           be_q;
  logic                 we_q, uns_q;
  logic [1:0]           lo_q, sz_q;
  logic [WB_WIDTH-1:0]  wb_q;
  logic [RDS_WIDTH-1:0] rds_q;

  logic                 memop, misal, go, tmo;
  logic [1:0]           sz, lo;
  logic [WIDTH-1:0]     sdata, wdata_n, lane, ld_fmt;
  logic [3:0]           be_n;
  logic [WB_WIDTH-1:0]  nx_wb;
  logic [WIDTH-1:0]     nx_data, nx_pc;
  logic [RDS_WIDTH-1:0] nx_rds;
  logic                 unused;

  assign sz    = i_MEM_Ctrl[3:2];
  assign lo    = i_ALU_rslt[1:0];
  assign memop = i_MEM_Ctrl[0] | i_MEM_Ctrl[1];
  assign misal = (sz == 2'b11) || (sz == 2'b01 && lo[0]) || (sz == 2'b10 && lo != 2'b00);
  assign go    = (state == IDLE) && memop && !misal;
  assign tmo   = (state == BUSY) && !i_dmem_ack && (tmo_cnt == 4'(TIMEOUT - 1));
  assign sdata = i_Fwrd_Store ? i_Data_From_WB : i_Rs2_val;
  assign unused = ^{i_Rs2_addr, lane[WIDTH-1:16]};

  always_comb begin
    be_n    = 4'b1111;
    wdata_n = sdata;
    case (sz)
      2'b00: begin be_n = 4'b0001 << lo; wdata_n = {4{sdata[7:0]}}; end
      2'b01: begin be_n = lo[1] ? 4'b1100 : 4'b0011; wdata_n = {2{sdata[15:0]}}; end
      default: ;
    endcase
  end

  // Shift the addressed lane down to bit 0, then extend by size/signedness.
  always_comb begin
    lane   = i_dmem_rdata >> {lo_q, 3'b000};
    ld_fmt = i_dmem_rdata;
    case (sz_q)
      2'b00:   ld_fmt = {{(WIDTH-8){~uns_q & lane[7]}}, lane[7:0]};
      2'b01:   ld_fmt = {{(WIDTH-16){~uns_q & lane[15]}}, lane[15:0]};
      default: ;
    endcase
  end

  assign o_dmem_req    = (state == BUSY);
  assign o_dmem_we     = we_q;
  assign o_dmem_addr   = addr_q;
  assign o_dmem_wdata  = wdata_q;
  assign o_dmem_be     = be_q;
  // Combinational terms are gated with reset so every output reads 0 while held in reset.
  assign o_MA_stall    = reset && (go || state == BUSY);
  assign o_misaligned  = reset && (state == IDLE) && memop && misal;
  assign o_bus_err     = tmo;
  assign o_Data_To_Fwd = !reset ? '0 : (state == DONE) ? cap_q : i_ALU_rslt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      tmo_cnt <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      lo_q    <= '0;
      sz_q    <= '0;
      cap_q   <= '0;
      wb_q    <= '0;
      rds_q   <= '0;
      pc_q    <= '0;
    end else begin
      case (state)
        IDLE: if (go) begin
          state   <= BUSY;
          tmo_cnt <= '0;
          addr_q  <= {i_ALU_rslt[WIDTH-1:2], 2'b00};
          we_q    <= i_MEM_Ctrl[1];
          be_q    <= be_n;
          wdata_q <= wdata_n;
          lo_q    <= lo;
          sz_q    <= sz;
          uns_q   <= i_MEM_Ctrl[4];
          wb_q    <= i_WB_Ctrl;
          rds_q   <= i_Rds_addr;
          pc_q    <= i_PC;
        end
        BUSY: if (i_dmem_ack) begin
          cap_q <= we_q ? '0 : ld_fmt;
          state <= DONE;
        end else if (tmo) begin
          cap_q <= '0;
          wb_q  <= '0;
          state <= DONE;
        end else begin
          tmo_cnt <= tmo_cnt + 4'd1;
        end
        DONE: if (!i_MAWB_stall) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Only IDLE without a bus access and DONE carry a result; IDLE-go and BUSY load bubbles.
  always_comb begin
    nx_wb   = '0;
    nx_data = '0;
    nx_rds  = '0;
    nx_pc   = '0;
    if (state == DONE) begin
      nx_wb   = wb_q;
      nx_data = cap_q;
      nx_rds  = rds_q;
      nx_pc   = pc_q;
    end else if (state == IDLE && !go) begin
      nx_wb   = memop ? '0 : i_WB_Ctrl;
      nx_data = i_ALU_rslt;
      nx_rds  = i_Rds_addr;
      nx_pc   = i_PC;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      o_MAWB_WB       <= '0;
      o_MAWB_Data     <= '0;
      o_MAWB_Rds_addr <= '0;
      o_MAWB_PC       <= '0;
    end else if (i_MAWB_flush) begin
      o_MAWB_WB       <= '0;
      o_MAWB_Data     <= '0;
      o_MAWB_Rds_addr <= '0;
      o_MAWB_PC       <= '0;
    end else if (!i_MAWB_stall) begin
      o_MAWB_WB       <= nx_wb;
      o_MAWB_Data     <= nx_data;
      o_MAWB_Rds_addr <= nx_rds;
      o_MAWB_PC       <= nx_pc;
    end
  end
endmodule

// File: tb/tb_ma_stage.sv
// Bench for ma_stage: per-operation expected traces queued by the driver and checked each cycle.
module tb_ma_stage;
  localparam int TMO = 15;

  logic        clk, reset;
  logic [1:0]  i_WB_Ctrl;
  logic [4:0]  i_MEM_Ctrl;
  logic [31:0] i_ALU_rslt, i_Rs2_val, i_PC, i_Data_From_WB, i_dmem_rdata;
  logic [4:0]  i_Rs2_addr, i_Rds_addr;
  logic        i_Fwrd_Store, i_MAWB_flush, i_MAWB_stall, i_dmem_ack;
  logic        o_dmem_req, o_dmem_we, o_MA_stall, o_misaligned, o_bus_err;
  logic [31:0] o_dmem_addr, o_dmem_wdata, o_Data_To_Fwd, o_MAWB_Data, o_MAWB_PC;
  logic [3:0]  o_dmem_be;
  logic [1:0]  o_MAWB_WB;
  logic [4:0]  o_MAWB_Rds_addr;

  ma_stage #(.WIDTH(32), .WB_WIDTH(2), .RDS_WIDTH(5), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .i_WB_Ctrl(i_WB_Ctrl), .i_MEM_Ctrl(i_MEM_Ctrl),
    .i_ALU_rslt(i_ALU_rslt), .i_Rs2_val(i_Rs2_val), .i_Rs2_addr(i_Rs2_addr),
    .i_Rds_addr(i_Rds_addr), .i_PC(i_PC), .i_Fwrd_Store(i_Fwrd_Store),
    .i_Data_From_WB(i_Data_From_WB), .i_MAWB_flush(i_MAWB_flush), .i_MAWB_stall(i_MAWB_stall),
    .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we), .o_dmem_addr(o_dmem_addr),
    .o_dmem_wdata(o_dmem_wdata), .o_dmem_be(o_dmem_be), .i_dmem_ack(i_dmem_ack),
    .i_dmem_rdata(i_dmem_rdata), .o_MA_stall(o_MA_stall), .o_misaligned(o_misaligned),
    .o_bus_err(o_bus_err), .o_Data_To_Fwd(o_Data_To_Fwd), .o_MAWB_WB(o_MAWB_WB),
    .o_MAWB_Data(o_MAWB_Data), .o_MAWB_Rds_addr(o_MAWB_Rds_addr), .o_MAWB_PC(o_MAWB_PC)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        req, stall, mis, berr, we;
    logic [31:0] addr, wdata, fwd, data, pc;
    logic [3:0]  be;
    logic [1:0]  wb;
    logic [4:0]  rds;
  } exp_t;

  exp_t        q[$];
  exp_t        ce;
  int          total = 0, bad = 0;
  int          cnt_req, cnt_stall, cnt_mis, cnt_berr;
  logic [3:0]  last_be;
  logic [31:0] last_wdata, last_addr;
  logic        rnd_ctl = 1'b0;
  // model of the MA/WB register contents
  logic [1:0]  m_wb = '0;
  logic [31:0] m_data = '0, m_pc = '0;
  logic [4:0]  m_rds = '0;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", n, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      ce = q.pop_front();
      cnt_req   += int'(o_dmem_req);
      cnt_stall += int'(o_MA_stall);
      cnt_mis   += int'(o_misaligned);
      cnt_berr  += int'(o_bus_err);
      if (o_dmem_req) begin last_be = o_dmem_be; last_wdata = o_dmem_wdata; last_addr = o_dmem_addr; end
      chk("req", o_dmem_req, ce.req);
      chk("stall", o_MA_stall, ce.stall);
      chk("misaligned", o_misaligned, ce.mis);
      chk("bus_err", o_bus_err, ce.berr);
      chk("fwd", o_Data_To_Fwd, ce.fwd);
      chk("mawb_wb", o_MAWB_WB, ce.wb);
      chk("mawb_data", o_MAWB_Data, ce.data);
      chk("mawb_rds", o_MAWB_Rds_addr, ce.rds);
      chk("mawb_pc", o_MAWB_PC, ce.pc);
      if (ce.req) begin
        chk("we", o_dmem_we, ce.we);
        chk("addr", o_dmem_addr, ce.addr);
      end
      if (ce.req && ce.we) begin
        chk("be", o_dmem_be, ce.be);
        chk("wdata", o_dmem_wdata, ce.wdata);
      end
    end
  end

  function automatic logic [31:0] load_val(input logic [31:0] w, input logic [1:0] a,
                                           input logic [1:0] sz, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[8*a +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    if (sz == 2'b00) return uns ? {24'h0, b} : {{24{b[7]}}, b};
    if (sz == 2'b01) return uns ? {16'h0, h} : {{16{h[15]}}, h};
    return w;
  endfunction

  // Queue this cycle's expectation, then apply the MA/WB rules (flush > stall > load) at the edge.
  task automatic cyc(input exp_t ei, input logic [1:0] nwb, input logic [31:0] nd,
                     input logic [4:0] nr, input logic [31:0] np);
    exp_t e;
    e = ei;
    e.wb = m_wb; e.data = m_data; e.rds = m_rds; e.pc = m_pc;
    q.push_back(e);
    @(posedge clk);
    if (i_MAWB_flush) begin
      m_wb = '0; m_data = '0; m_rds = '0; m_pc = '0;
    end else if (!i_MAWB_stall) begin
      m_wb = nwb; m_data = nd; m_rds = nr; m_pc = np;
    end
    #1;
  endtask

  task automatic set_inst(input logic [4:0] mc, input logic [31:0] a, input logic [31:0] rs2,
                          input logic fw, input logic [31:0] fwd, input logic [1:0] wb);
    i_MEM_Ctrl = mc; i_ALU_rslt = a; i_Rs2_val = rs2; i_Fwrd_Store = fw;
    i_Data_From_WB = fwd; i_WB_Ctrl = wb;
    i_Rds_addr = 5'($urandom); i_Rs2_addr = 5'($urandom); i_PC = $urandom;
  endtask

  task automatic op(input int waits, input logic [31:0] rdata, input int dstall);
    logic [4:0]  mc, rds;
    logic [31:0] a, sd, ewd, cap, pc;
    logic [3:0]  ebe;
    logic [1:0]  sz, ewb;
    logic        memop, mis, tmo, done;
    exp_t        e;
    mc = i_MEM_Ctrl; a = i_ALU_rslt; sz = mc[3:2]; memop = mc[0] | mc[1];
    mis = memop && (sz == 2'b11 || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00));
    if (rnd_ctl) begin
      i_MAWB_stall = ($urandom_range(0, 4) == 0);
      i_MAWB_flush = ($urandom_range(0, 9) == 0);
    end
    i_dmem_ack = 1'b0;
    e = '0; e.fwd = a;
    if (!memop) cyc(e, i_WB_Ctrl, a, i_Rds_addr, i_PC);
    else if (mis) begin e.mis = 1'b1; cyc(e, 2'b00, a, i_Rds_addr, i_PC); end
    else begin
      sd = i_Fwrd_Store ? i_Data_From_WB : i_Rs2_val;
      if (sz == 2'b00)      begin ebe = 4'b0001 << a[1:0]; ewd = {4{sd[7:0]}}; end
      else if (sz == 2'b01) begin ebe = a[1] ? 4'b1100 : 4'b0011; ewd = {2{sd[15:0]}}; end
      else                  begin ebe = 4'b1111; ewd = sd; end
      ewb = i_WB_Ctrl; rds = i_Rds_addr; pc = i_PC;
      e.stall = 1'b1;
      cyc(e, '0, '0, '0, '0);
      tmo = (waits >= TMO); done = 1'b0;
      for (int k = 0; !done; k++) begin
        if (rnd_ctl) begin
          i_MAWB_stall = ($urandom_range(0, 4) == 0);
          i_MAWB_flush = ($urandom_range(0, 9) == 0);
        end
        i_Rs2_val = $urandom; i_Data_From_WB = $urandom;
        e = '0; e.req = 1'b1; e.stall = 1'b1; e.we = mc[1]; e.addr = {a[31:2], 2'b00};
        e.be = ebe; e.wdata = ewd; e.fwd = a;
        i_dmem_ack = !tmo && (k == waits);
        i_dmem_rdata = i_dmem_ack ? rdata : $urandom;
        e.berr = tmo && (k == TMO - 1);
        done = i_dmem_ack || e.berr;
        cyc(e, '0, '0, '0, '0);
      end
      i_dmem_ack = 1'b0;
      cap = (tmo || mc[1]) ? 32'h0 : load_val(rdata, a[1:0], sz, mc[4]);
      if (tmo) ewb = 2'b00;
      for (int d = 0; d <= dstall; d++) begin
        i_MAWB_stall = (d < dstall);
        i_MAWB_flush = rnd_ctl && ($urandom_range(0, 9) == 0);
        e = '0; e.fwd = cap;
        cyc(e, ewb, cap, rds, pc);
      end
      i_MAWB_stall = 1'b0; i_MAWB_flush = 1'b0;
    end
  endtask

  task automatic clr_cnt();
    cnt_req = 0; cnt_stall = 0; cnt_mis = 0; cnt_berr = 0;
  endtask

  initial begin
    logic [31:0] a;
    logic [1:0]  kind;
    reset = 1'b0; i_MAWB_flush = 1'b0; i_MAWB_stall = 1'b0; i_dmem_ack = 1'b0; i_dmem_rdata = '0;
    i_Rs2_addr = '0; i_Rds_addr = '0; i_PC = '0; i_Rs2_val = '0; i_Fwrd_Store = 1'b0;
    i_Data_From_WB = '0; i_WB_Ctrl = 2'b11; i_MEM_Ctrl = 5'b01001; i_ALU_rslt = 32'h100;
    clr_cnt();
    #12;
    chk("rst_req", o_dmem_req, 0);
    chk("rst_stall", o_MA_stall, 0);
    chk("rst_fwd", o_Data_To_Fwd, 0);
    chk("rst_mawb_wb", o_MAWB_WB, 0);
    chk("rst_mawb_data", o_MAWB_Data, 0);
    i_MEM_Ctrl = '0;
    @(posedge clk); #1 reset = 1'b1;

    // word load, three wait states
    set_inst(5'b01001, 32'h100, 0, 0, 0, 2'b01); clr_cnt();
    op(3, 32'hDEADBEEF, 0);
    chk("t1_req_cycles", cnt_req, 4);
    chk("t1_stall_cycles", cnt_stall, 5);
    chk("t1_data", o_MAWB_Data, 32'hDEADBEEF);

    // signed / unsigned byte load from lane 3
    set_inst(5'b00001, 32'h103, 0, 0, 0, 2'b01); op(0, 32'h80112233, 0);
    chk("t2_signed", o_MAWB_Data, 32'hFFFFFF80);
    set_inst(5'b10001, 32'h103, 0, 0, 0, 2'b01); op(0, 32'h80112233, 0);
    chk("t2_unsigned", o_MAWB_Data, 32'h00000080);

    // half store of forwarded data
    set_inst(5'b00110, 32'h202, 32'h0000ABCD, 1'b1, 32'h00001234, 2'b10); op(1, 0, 0);
    chk("t3_be", last_be, 4'b1100);
    chk("t3_wdata", last_wdata, 32'h12341234);
    chk("t3_addr", last_addr, 32'h200);
    chk("t3_data", o_MAWB_Data, 0);

    // misaligned word load
    set_inst(5'b01001, 32'h101, 0, 0, 0, 2'b11); clr_cnt(); op(0, 0, 0);
    chk("t4_mis_pulses", cnt_mis, 1);
    chk("t4_req_cycles", cnt_req, 0);
    chk("t4_stall_cycles", cnt_stall, 0);
    chk("t4_wb", o_MAWB_WB, 0);

    // bus timeout
    set_inst(5'b01001, 32'h180, 0, 0, 0, 2'b11); clr_cnt(); op(99, 0, 0);
    chk("t5_berr_pulses", cnt_berr, 1);
    chk("t5_req_cycles", cnt_req, TMO);
    chk("t5_data", o_MAWB_Data, 0);
    chk("t5_wb", o_MAWB_WB, 0);
    set_inst(5'b00000, 32'h55, 0, 0, 0, 2'b01); op(0, 0, 0);

    // reset in the middle of BUSY
    set_inst(5'b01001, 32'h300, 0, 0, 0, 2'b11);
    begin
      exp_t e;
      e = '0; e.stall = 1'b1; e.fwd = 32'h300; cyc(e, '0, '0, '0, '0);
      e.req = 1'b1; e.addr = 32'h300; cyc(e, '0, '0, '0, '0);
    end
    #2 reset = 1'b0; #1;
    chk("t6_rst_req", o_dmem_req, 0);
    chk("t6_rst_stall", o_MA_stall, 0);
    chk("t6_rst_addr", o_dmem_addr, 0);
    i_MEM_Ctrl = '0;
    @(posedge clk); @(posedge clk); #1 reset = 1'b1;
    m_wb = '0; m_data = '0; m_rds = '0; m_pc = '0;

    // DONE held by MA/WB stall, then flush+stall together
    set_inst(5'b01001, 32'h400, 0, 0, 0, 2'b01); op(1, 32'hCAFEF00D, 2);
    chk("t6_done_data", o_MAWB_Data, 32'hCAFEF00D);
    set_inst(5'b00000, 32'h77, 0, 0, 0, 2'b01);
    i_MAWB_flush = 1'b1; i_MAWB_stall = 1'b1; op(0, 0, 0);
    i_MAWB_flush = 1'b0; i_MAWB_stall = 1'b0;
    chk("t6_flush_data", o_MAWB_Data, 0);
    chk("t6_flush_pc", o_MAWB_PC, 0);

    // randomized mix
    rnd_ctl = 1'b1;
    for (int n = 0; n < 400; n++) begin
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      kind = 2'($urandom_range(0, 3));
      set_inst({1'($urandom), 2'($urandom), kind}, a, $urandom, 1'($urandom), $urandom, 2'($urandom));
      op(($urandom_range(0, 19) == 0) ? 99 : $urandom_range(0, 4), $urandom,
         ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0);
    end
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
